// File: rtl/conv_bias_seq_if.sv
// Bias sequencer bundle: controller-side request/load signals and the
// bias-add-side output stream.
interface conv_bias_seq_if #(
  parameter int BIAS_WIDTH = 8,
  parameter int CH_WIDTH   = 5
);
  logic                  start;
  logic                  req;
  logic                  ld_en;
  logic [CH_WIDTH-1:0]   ld_addr;
  logic [BIAS_WIDTH-1:0] ld_data;
  logic                  busy;
  logic                  b_valid;
  logic [BIAS_WIDTH-1:0] b_data;
  logic [CH_WIDTH-1:0]   b_ch;
  logic                  done;

  modport master (
    output start, req, ld_en, ld_addr, ld_data,
    input  busy, b_valid, b_data, b_ch, done
  );

  modport slave (
    input  start, req, ld_en, ld_addr, ld_data,
    output busy, b_valid, b_data, b_ch, done
  );
endinterface

// File: rtl/conv_bias_seq.sv
// Per-output-channel bias sequencer: loadable bias register file walked one
// channel per accepted request, two-cycle read latency.
// Optional build macro CONV_BIAS_SEQ_WRAP_EN: passes repeat without a new start.
module conv_bias_seq #(
  parameter int BIAS_WIDTH = 8,
  parameter int NUM_CH     = 18,
  parameter int CH_WIDTH   = 5
) (
  input  logic           clk,
  input  logic           rst,
  conv_bias_seq_if.slave bus
);

  localparam logic [CH_WIDTH-1:0] LAST_CH    = CH_WIDTH'(NUM_CH - 1);
  localparam logic [CH_WIDTH:0]   NUM_CH_EXT = (CH_WIDTH + 1)'(NUM_CH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                       state;
  logic                         busy_q;
  logic [CH_WIDTH-1:0]          ch;
  logic signed [BIAS_WIDTH-1:0] rf [NUM_CH];
  logic                         accept;

  logic                         vld_p1;
  logic [CH_WIDTH-1:0]          ch_p1;
  logic signed [BIAS_WIDTH-1:0] data_p1;

  logic                         vld_p2;
  logic                         done_p2;
  logic [CH_WIDTH-1:0]          ch_p2;
  logic signed [BIAS_WIDTH-1:0] data_p2;

  // Extra MSB lets the bound check work even when NUM_CH == 2^CH_WIDTH.
  function automatic logic addr_in_range(input logic [CH_WIDTH-1:0] addr);
    return {1'b0, addr} < NUM_CH_EXT;
  endfunction

  // start wins over a coincident req
  assign accept = (state == RUN) && bus.req && !bus.start;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      busy_q <= 1'b0;
      ch     <= '0;
    end else if (bus.start) begin
      state  <= RUN;
      busy_q <= 1'b1;
      ch     <= '0;
    end else if (accept) begin
      if (ch == LAST_CH) begin
`ifdef CONV_BIAS_SEQ_WRAP_EN
        ch     <= '0;
`else
        state  <= DONE;
        busy_q <= 1'b0;
`endif
      end else begin
        ch <= ch + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) rf[i] <= '0;
    end else if (bus.ld_en && addr_in_range(bus.ld_addr)) begin
      rf[bus.ld_addr] <= bus.ld_data;
    end
  end

  // Stage 1: latch channel index and read the register file (pre-write value)
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      ch_p1   <= '0;
      data_p1 <= '0;
    end else begin
      vld_p1 <= accept;
      if (accept) begin
        ch_p1   <= ch;
        data_p1 <= rf[ch];
      end
    end
  end

  // Stage 2: output register; data and index hold while not valid
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2  <= 1'b0;
      done_p2 <= 1'b0;
      ch_p2   <= '0;
      data_p2 <= '0;
    end else begin
      vld_p2  <= vld_p1;
      done_p2 <= vld_p1 && (ch_p1 == LAST_CH);
      if (vld_p1) begin
        ch_p2   <= ch_p1;
        data_p2 <= data_p1;
      end
    end
  end

  assign bus.busy    = busy_q;
  assign bus.b_valid = vld_p2;
  assign bus.b_data  = data_p2;
  assign bus.b_ch    = ch_p2;
  assign bus.done    = done_p2;

endmodule
